rec_axis_packer: RTL and testbench
==================================

Name: rec_axis_packer

Overview:
- Downstream of the rectify stage. Consumes its unthrottled rectified pixel stream (recvalid/recpixel/reclast) and packs 4 pixels into 32-bit words.
- Buffers the words in an internal FIFO and presents them as an AXI4-Stream master with backpressure, for the DMA/frame-writer.
- Marks start-of-frame (tuser) and end-of-line (tlast), and checks frame geometry against reclast.

Parameters:
- COL, 640, pixels per line; must be a multiple of 4.
- ROW, 480, lines per frame.
- FIFO_DEPTH, 64, word entries in the output FIFO; power of 2, at least 4.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- recvalid  in  1  rectified pixel valid. There is no ready; the pixel must be taken in the cycle it is valid.
- recpixel  in  8  rectified pixel value.
- reclast  in  1  high with the last pixel of a frame.
- m_tdata  out  32  packed word; the earliest pixel is in [7:0], the latest in [31:24].
- m_tvalid  out  1  AXI-S valid.
- m_tready  in  1  AXI-S ready.
- m_tlast  out  1  last word of a line.
- m_tuser  out  1  first word of a frame.
- overflow  out  1  sticky; a word was dropped because the FIFO was full.
- frame_done  out  1  one-cycle pulse when the last word of a correctly-sized frame is written to the FIFO.
- frame_err  out  1  one-cycle pulse on a geometry mismatch.

Behaviour:
- Reset:
  - m_tvalid, m_tlast, m_tuser, overflow, frame_done and frame_err are 0. m_tdata is 0.
  - The FIFO is emptied; the column counter, row counter and byte-lane index are set to 0.
  - A reset in mid-frame discards everything. The next recvalid is treated as pixel (0,0).
- Packing:
  - Each cycle with recvalid=1, recpixel is stored in lane col[1:0], and col increments.
  - On lane 3 the complete word is formed with flags:
    - tuser = (row==0 && col==3)
    - tlast = (col==COL-1)
  - col wraps to 0 at COL-1 and row increments. row wraps to 0 at ROW-1.
- Frame check:
  - Expected end of frame: row==ROW-1 && col==COL-1.
  - reclast=1 at the expected pixel: the word is written normally, frame_done pulses on the cycle after that edge, and the counters wrap to 0.
  - reclast=1 at any other pixel:
    - frame_err pulses.
    - Any partial word, including this pixel, is discarded and nothing is written for it.
    - Counters reset to 0.
  - Expected end reached with reclast=0:
    - The word is written, with tlast=1.
    - frame_err pulses and frame_done does not.
    - Counters wrap to 0 normally.
- FIFO:
  - First-word-fall-through; entries are {tuser, tlast, data}, 34 bits.
  - Write happens on the edge after the edge that samples the lane-3 pixel, so there is a one-cycle pack register.
  - From an empty FIFO, m_tvalid rises 2 cycles after the lane-3 pixel edge.
  - A read occurs on any edge with m_tvalid && m_tready.
  - Outputs m_tdata/m_tlast/m_tuser hold steady while m_tvalid && !m_tready.
  - Simultaneous read and write while full: the write is accepted.
- Overflow: when full with no read in the same cycle, the pending word is dropped and overflow sets until rst. Packing and counting continue unaffected.
- Throughput: at most 1 word per 4 input cycles in, 1 word per cycle out. With m_tready held at 1, the FIFO never exceeds 1 entry.

Test Plan:
- COL=8, ROW=2, FIFO_DEPTH=4, m_tready=1; pixels 0..15 continuous, reclast on pixel 15:
  - 4 words out: 0x03020100 (tuser=1), 0x07060504 (tlast=1), 0x0B0A0908, 0x0F0E0D0C (tlast=1).
  - frame_done pulses once; frame_err stays 0.
  - Each word's m_tvalid appears 2 cycles after its lane-3 pixel.
- Same stimulus with m_tready=0 for 30 cycles, then 1:
  - 4 words are held and then drained in order with identical values.
  - m_tdata is stable while stalled; overflow=0.
- Same settings; two back-to-back frames (32 pixels) with m_tready=0:
  - The first 4 words are stored and the remaining 4 are dropped; overflow sets and stays 1.
  - After m_tready=1, exactly 4 words from frame 1 emerge.
- reclast asserted on pixel 9:
  - frame_err pulses once; no frame_done.
  - The word holding pixels 8–9 is not emitted.
  - The next pixel is packed as a tuser=1 word.
- 16 pixels without reclast:
  - 4 words are emitted; frame_err pulses after pixel 15 and frame_done stays 0.
  - The next word carries tuser=1.
- rst pulsed after pixel 6 with 1 word buffered:
  - m_tvalid drops to 0 the cycle after the rst edge; overflow clears.
  - The next 16 pixels produce a clean frame as in the first scenario.

Source files
------------

// File: rtl/rec_axis_packer.sv
// rec_axis_packer: packs the rectified pixel stream into 32-bit words
// and serves them through a small FIFO as an AXI4-Stream master.
module rec_axis_packer #(
    parameter int COL        = 640,
    parameter int ROW        = 480,
    parameter int FIFO_DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        recvalid,
    input  logic [7:0]  recpixel,
    input  logic        reclast,
    output logic [31:0] m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tlast,
    output logic        m_tuser,
    output logic        overflow,
    output logic        frame_done,
    output logic        frame_err
);

    localparam int CW = $clog2(COL);
    localparam int RW = (ROW > 1) ? $clog2(ROW) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [23:0]   lanes;
    logic          pk_valid;
    logic [33:0]   pk_word;

    logic [33:0]   mem [FIFO_DEPTH];
    logic [AW:0]   wptr;
    logic [AW:0]   rptr;
    logic          empty;
    logic          full;
    logic          rd;
    logic          wr;
    logic          at_end;
    logic          col_end;

    assign col_end = (col == CW'(COL - 1));
    assign at_end  = col_end && (row == RW'(ROW - 1));
    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) &&
                     (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rd      = !empty && m_tready;
    assign wr      = pk_valid && (!full || rd);

    // Lane packing, geometry tracking and frame check; one-cycle pack register
    always_ff @(posedge clk) begin
        if (rst) begin
            col        <= '0;
            row        <= '0;
            lanes      <= '0;
            pk_valid   <= 1'b0;
            pk_word    <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            pk_valid   <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            if (recvalid) begin
                if (reclast && !at_end) begin
                    // early end of frame: drop the partial word, restart
                    frame_err <= 1'b1;
                    col       <= '0;
                    row       <= '0;
                end else begin
                    case (col[1:0])
                        2'd0: lanes[7:0]   <= recpixel;
                        2'd1: lanes[15:8]  <= recpixel;
                        2'd2: lanes[23:16] <= recpixel;
                        2'd3: begin
                            pk_valid <= 1'b1;
                            pk_word  <= {(row == '0) && (col == CW'(3)),
                                         col_end, recpixel, lanes};
                        end
                    endcase
                    if (col_end) begin
                        col <= '0;
                        if (row == RW'(ROW - 1))
                            row <= '0;
                        else
                            row <= row + 1'b1;
                    end else begin
                        col <= col + 1'b1;
                    end
                    if (at_end) begin
                        if (reclast)
                            frame_done <= 1'b1;
                        else
                            frame_err <= 1'b1;
                    end
                end
            end
        end
    end

    // FIFO storage; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (wr)
            mem[wptr[AW-1:0]] <= pk_word;
    end

    // FIFO pointers and sticky overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr)
                wptr <= wptr + 1'b1;
            if (rd)
                rptr <= rptr + 1'b1;
            if (pk_valid && full && !rd)
                overflow <= 1'b1;
        end
    end

    // First-word-fall-through head; zeroed while empty
    always_comb begin
        m_tvalid = !empty;
        {m_tuser, m_tlast, m_tdata} = '0;
        if (!empty)
            {m_tuser, m_tlast, m_tdata} = mem[rptr[AW-1:0]];
    end

endmodule

// File: tb/tb_rec_axis_packer.sv
// tb_rec_axis_packer: scoreboard bench for rec_axis_packer
// with a small geometry (8x2 frame, 4-entry FIFO).
module tb_rec_axis_packer;

    localparam int COL   = 8;
    localparam int ROW   = 2;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        recvalid = 1'b0;
    logic [7:0]  recpixel = '0;
    logic        reclast = 1'b0;
    logic        m_tready = 1'b0;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tuser;
    logic        overflow;
    logic        frame_done;
    logic        frame_err;

    rec_axis_packer #(
        .COL(COL),
        .ROW(ROW),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .recvalid(recvalid),
        .recpixel(recpixel),
        .reclast(reclast),
        .m_tdata(m_tdata),
        .m_tvalid(m_tvalid),
        .m_tready(m_tready),
        .m_tlast(m_tlast),
        .m_tuser(m_tuser),
        .overflow(overflow),
        .frame_done(frame_done),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        user;
        logic        last;
        int          due;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          fd_cnt = 0;
    int          fe_cnt = 0;
    int          n_pop = 0;
    bit          hold_en = 1'b0;
    bit          prev_hold = 1'b0;
    logic [31:0] prev_data = '0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Output monitor: pulse counting, stall stability, scoreboard pops
    always @(negedge clk) begin
        if (frame_done) fd_cnt++;
        if (frame_err) fe_cnt++;
        if (hold_en && prev_hold) begin
            chk("hold_valid", m_tvalid, 1);
            chk("hold_data", m_tdata, prev_data);
        end
        prev_hold = m_tvalid && !m_tready;
        prev_data = m_tdata;
        if (m_tvalid && m_tready) begin
            n_pop++;
            if (sb.size() == 0) begin
                chk("extra_word", m_tdata, 64'hffff_ffff_ffff_ffff);
            end else begin
                mon_e = sb.pop_front();
                chk("tdata", m_tdata, mon_e.data);
                chk("tuser", m_tuser, mon_e.user);
                chk("tlast", m_tlast, mon_e.last);
                if (mon_e.due >= 0)
                    chk("latency", cyc, mon_e.due);
            end
        end
    end

    task automatic drive_pixel(input logic [7:0] p, input logic last);
        @(posedge clk);
        #1;
        recvalid = 1'b1;
        recpixel = p;
        reclast  = last;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            recvalid = 1'b0;
            reclast  = 1'b0;
        end
    endtask

    task automatic frame16(input int base, input bit last15,
                           input bit push, input bit with_due);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < 16; i++) begin
            drive_pixel(8'(base + i), last15 && (i == 15));
            w = {8'(base + i), w[31:8]};
            if (push && (i % 4 == 3))
                sb.push_back('{data: w, user: (i == 3),
                               last: (i % 8 == 7),
                               due: with_due ? cyc + 2 : -1});
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst      = 1'b1;
        recvalid = 1'b0;
        reclast  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        fd_cnt = 0;
        fe_cnt = 0;
        n_pop  = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_tdata", m_tdata, 0);
        chk("rst_tlast", m_tlast, 0);
        chk("rst_tuser", m_tuser, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_err", frame_err, 0);

        // clean frame, ready held high, latency checked
        m_tready = 1'b1;
        frame16(0, 1, 1, 1);
        idle(1);
        @(negedge clk);
        chk("s1_done_pulse", frame_done, 1);
        idle(8);
        chk("s1_drain", sb.size(), 0);
        chk("s1_pops", n_pop, 4);
        chk("s1_done_cnt", fd_cnt, 1);
        chk("s1_err_cnt", fe_cnt, 0);

        // stalled sink for 30 cycles, then drain
        do_reset();
        m_tready = 1'b0;
        hold_en  = 1'b1;
        frame16(8'h40, 1, 1, 0);
        idle(14);
        chk("s2_ovf", overflow, 0);
        chk("s2_valid", m_tvalid, 1);
        m_tready = 1'b1;
        idle(10);
        hold_en = 1'b0;
        chk("s2_drain", sb.size(), 0);
        chk("s2_pops", n_pop, 4);
        chk("s2_done_cnt", fd_cnt, 1);
        chk("s2_err_cnt", fe_cnt, 0);

        // two frames into a stalled 4-entry FIFO
        do_reset();
        m_tready = 1'b0;
        frame16(8'h80, 1, 1, 0);
        frame16(8'h90, 1, 0, 0);
        idle(2);
        chk("s3_ovf_set", overflow, 1);
        chk("s3_err_cnt", fe_cnt, 0);
        idle(5);
        m_tready = 1'b1;
        idle(10);
        chk("s3_drain", sb.size(), 0);
        chk("s3_pops", n_pop, 4);
        chk("s3_ovf_sticky", overflow, 1);

        // reset mid-frame with one word buffered and overflow set
        m_tready = 1'b0;
        for (int i = 0; i < 7; i++)
            drive_pixel(8'(8'hA0 + i), 1'b0);
        @(negedge clk);
        chk("s6_buffered", m_tvalid, 1);
        chk("s6_ovf_pre", overflow, 1);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        recvalid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("s6_valid_drop", m_tvalid, 0);
        chk("s6_ovf_clear", overflow, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        fd_cnt = 0;
        fe_cnt = 0;
        n_pop  = 0;
        m_tready = 1'b1;
        frame16(0, 1, 1, 1);
        idle(1);
        @(negedge clk);
        chk("s6_done_pulse", frame_done, 1);
        idle(8);
        chk("s6_drain", sb.size(), 0);
        chk("s6_pops", n_pop, 4);
        chk("s6_done_cnt", fd_cnt, 1);
        chk("s6_err_cnt", fe_cnt, 0);

        // early reclast on pixel 9
        do_reset();
        m_tready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive_pixel(8'(i), i == 9);
            if (i == 3)
                sb.push_back('{32'h03020100, 1'b1, 1'b0, cyc + 2});
            if (i == 7)
                sb.push_back('{32'h07060504, 1'b0, 1'b1, cyc + 2});
        end
        idle(1);
        @(negedge clk);
        chk("s4_err_pulse", frame_err, 1);
        for (int i = 0; i < 4; i++) begin
            drive_pixel(8'(8'h20 + i), 1'b0);
            if (i == 3)
                sb.push_back('{32'h23222120, 1'b1, 1'b0, cyc + 2});
        end
        idle(8);
        chk("s4_drain", sb.size(), 0);
        chk("s4_pops", n_pop, 3);
        chk("s4_err_cnt", fe_cnt, 1);
        chk("s4_done_cnt", fd_cnt, 0);

        // missing reclast at expected end of frame
        do_reset();
        m_tready = 1'b1;
        frame16(8'h10, 0, 1, 1);
        idle(1);
        @(negedge clk);
        chk("s5_err_pulse", frame_err, 1);
        chk("s5_no_done", frame_done, 0);
        for (int i = 0; i < 4; i++) begin
            drive_pixel(8'(8'h50 + i), 1'b0);
            if (i == 3)
                sb.push_back('{32'h53525150, 1'b1, 1'b0, cyc + 2});
        end
        idle(8);
        chk("s5_drain", sb.size(), 0);
        chk("s5_pops", n_pop, 5);
        chk("s5_err_cnt", fe_cnt, 1);
        chk("s5_done_cnt", fd_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
